// File: rtl/dds_key_ctrl.sv
// DDS key controller: turns debounced key pulses into waveform/FTW config transactions.
// Each serviced press updates the settings, recomputes the FTW if needed, then runs one valid/ready handshake.
module dds_key_ctrl #(
  parameter int unsigned       FTW_W    = 32,
  parameter int unsigned       IDX_W    = 6,
  parameter int unsigned       IDX_MAX  = 50,
  parameter logic [FTW_W-1:0]  FTW_STEP = 32'd8590
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       key_neg,
  input  logic             cfg_ready,
  output logic             cfg_valid,
  output logic [1:0]       wave_sel,
  output logic [IDX_W-1:0] freq_idx,
  output logic [FTW_W-1:0] ftw,
  output logic             busy
);

  typedef enum logic [1:0] {StIdle, StCalc, StSend} state_e;

  localparam int unsigned      PW       = FTW_W + IDX_W;
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_TOP  = IDX_W'(IDX_MAX);
  localparam logic [IDX_W-1:0] CNT_LAST = IDX_W'(IDX_W - 1);

  state_e           state;
  logic [2:0]       pend;
  logic [2:0]       svc;
  logic [2:0]       pend_next;
  logic [IDX_W-1:0] idx_up;
  logic [IDX_W-1:0] idx_dn;
  logic [IDX_W-1:0] idx_new;
  logic [PW-1:0]    acc;
  logic [PW-1:0]    mcand;
  logic [PW-1:0]    acc_next;
  logic [IDX_W-1:0] mplier;
  logic [IDX_W-1:0] cnt;

  // One key per IDLE visit, lowest index first.
  always_comb begin
    svc = 3'b000;
    if (state == StIdle) begin
      if (pend[0])      svc = 3'b001;
      else if (pend[1]) svc = 3'b010;
      else if (pend[2]) svc = 3'b100;
    end
  end

  // A fresh pulse on the service edge keeps its flag set.
  assign pend_next = (pend & ~svc) | key_neg;

  assign idx_up   = (freq_idx == IDX_TOP) ? IDX_ONE : freq_idx + IDX_ONE;
  assign idx_dn   = (freq_idx == IDX_ONE) ? IDX_TOP : freq_idx - IDX_ONE;
  assign idx_new  = svc[1] ? idx_up : idx_dn;
  assign acc_next = acc + (mplier[0] ? mcand : '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= StIdle;
      pend      <= 3'b000;
      wave_sel  <= 2'd0;
      freq_idx  <= IDX_ONE;
      ftw       <= FTW_STEP;
      cfg_valid <= 1'b0;
      busy      <= 1'b0;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      cnt       <= '0;
    end else begin
      pend <= pend_next;
      unique case (state)
        StIdle: begin
          if (svc[0]) begin
            wave_sel <= wave_sel + 2'd1;
            state    <= StSend;
            busy     <= 1'b1;
          end else if (svc[1] || svc[2]) begin
            freq_idx <= idx_new;
            acc      <= '0;
            mcand    <= PW'(FTW_STEP);
            mplier   <= idx_new;
            cnt      <= '0;
            state    <= StCalc;
            busy     <= 1'b1;
          end
        end
        StCalc: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + IDX_ONE;
          if (cnt == CNT_LAST) begin
            ftw   <= acc_next[FTW_W-1:0];
            state <= StSend;
          end
        end
        StSend: begin
          // One settle cycle in SEND before raising valid.
          if (!cfg_valid) begin
            cfg_valid <= 1'b1;
          end else if (cfg_ready) begin
            cfg_valid <= 1'b0;
            state     <= StIdle;
            busy      <= 1'b0;
          end
        end
        default: begin
          state <= StIdle;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dds_key_ctrl.sv
// Self-checking bench for dds_key_ctrl: directed scenarios plus randomized single presses
// checked against an arithmetic model of wave/index/FTW.
module tb_dds_key_ctrl;

  localparam int IDX_W = 6;
  localparam int STEP  = 8590;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  key_neg;
  logic        cfg_ready;
  logic        cfg_valid;
  logic [1:0]  wave_sel;
  logic [5:0]  freq_idx;
  logic [31:0] ftw;
  logic        busy;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [1:0] m_wave;
  int         m_idx;

  dds_key_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .key_neg   (key_neg),
    .cfg_ready (cfg_ready),
    .cfg_valid (cfg_valid),
    .wave_sel  (wave_sel),
    .freq_idx  (freq_idx),
    .ftw       (ftw),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_ftw(input int idx);
    return 32'(idx * STEP);
  endfunction

  task automatic model_key(input int k);
    if (k == 0) m_wave = m_wave + 2'd1;
    else if (k == 1) m_idx = (m_idx == 50) ? 1 : m_idx + 1;
    else m_idx = (m_idx == 1) ? 50 : m_idx - 1;
  endtask

  task automatic check_outs(input string tag);
    check({tag, "_wave"}, 64'(wave_sel), 64'(m_wave));
    check({tag, "_idx"}, 64'(freq_idx), 64'(m_idx));
    check({tag, "_ftw"}, 64'(ftw), 64'(exp_ftw(m_idx)));
    check({tag, "_busy"}, 64'(busy), 64'd1);
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (cfg_valid !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
  endtask

  // One press of key k; ready high up front when stall==0, else held low for stall cycles.
  task automatic txn(input int k, input int stall);
    int n;
    model_key(k);
    cfg_ready = (stall == 0);
    key_neg = 3'(1 << k);
    tick();
    key_neg = 3'b000;
    wait_valid(n);
    check("latency", 64'(n), (k == 0) ? 64'd2 : 64'(2 + IDX_W));
    check_outs("txn");
    for (int i = 0; i < stall; i++) begin
      tick();
      check("stall_valid", 64'(cfg_valid), 64'd1);
      check_outs("stall");
    end
    cfg_ready = 1'b1;
    tick();
    check("handshake_drop", 64'(cfg_valid), 64'd0);
    check("handshake_busy", 64'(busy), 64'd0);
    cfg_ready = 1'b0;
  endtask

  initial begin
    int n;
    int seen;
    rst = 1'b1;
    key_neg = 3'b000;
    cfg_ready = 1'b0;
    m_wave = 2'd0;
    m_idx = 1;

    // Reset
    tick();
    tick();
    rst = 1'b0;
    check("rst_wave", 64'(wave_sel), 64'd0);
    check("rst_idx", 64'(freq_idx), 64'd1);
    check("rst_ftw", 64'(ftw), 64'd8590);
    check("rst_valid", 64'(cfg_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (cfg_valid !== 1'b0) seen++;
    end
    check("rst_no_txn", 64'(seen), 64'd0);

    // key1 with ready high
    txn(1, 0);
    check("up_ftw_const", 64'(ftw), 64'd17180);

    // Wrap around both ends
    txn(2, 0);
    txn(2, 0);
    check("down_wrap_idx", 64'(freq_idx), 64'd50);
    txn(1, 0);
    check("up_wrap_idx", 64'(freq_idx), 64'd1);
    check("up_wrap_ftw", 64'(ftw), 64'd8590);
    txn(2, 0);
    check("down_wrap_ftw", 64'(ftw), 64'd429500);

    // key0 x5
    for (int i = 0; i < 5; i++) begin
      txn(0, 0);
      repeat (6) tick();
    end
    check("wave_after5", 64'(wave_sel), 64'(m_wave));

    // Backpressure with presses during the stall
    model_key(0);
    cfg_ready = 1'b0;
    key_neg = 3'b001;
    tick();
    key_neg = 3'b000;
    wait_valid(n);
    check("bp_latency", 64'(n), 64'd2);
    for (int i = 0; i < 20; i++) begin
      key_neg = (i == 3 || i == 11) ? 3'b001 : ((i == 7) ? 3'b100 : 3'b000);
      tick();
      key_neg = 3'b000;
      check("bp_valid", 64'(cfg_valid), 64'd1);
      check_outs("bp_hold");
    end
    cfg_ready = 1'b1;
    tick();
    check("bp_drop", 64'(cfg_valid), 64'd0);
    model_key(0);
    wait_valid(n);
    check("bp_second_lat", 64'(n), 64'd2);
    check_outs("bp_second");
    tick();
    model_key(2);
    wait_valid(n);
    check("bp_third_lat", 64'(n), 64'(2 + IDX_W));
    check_outs("bp_third");
    tick();
    check("bp_third_drop", 64'(cfg_valid), 64'd0);
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (cfg_valid !== 1'b0) seen++;
    end
    check("bp_exactly_two", 64'(seen), 64'd0);
    cfg_ready = 1'b0;

    // Reset during CALC
    key_neg = 3'b110;
    tick();
    key_neg = 3'b000;
    repeat (3) tick();
    check("calc_busy", 64'(busy), 64'd1);
    check("calc_no_valid", 64'(cfg_valid), 64'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_wave = 2'd0;
    m_idx = 1;
    check("abort_valid", 64'(cfg_valid), 64'd0);
    check("abort_idx", 64'(freq_idx), 64'd1);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_ftw", 64'(ftw), 64'd8590);
    cfg_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (cfg_valid !== 1'b0 || busy !== 1'b0) seen++;
    end
    check("abort_pend_lost", 64'(seen), 64'd0);
    cfg_ready = 1'b0;

    // Randomized single presses against the model
    for (int i = 0; i < 40; i++) begin
      txn(int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
      repeat ($urandom_range(0, 3)) tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
